// File: rtl/qtree_loader_pkg.sv
// rtl/qtree_loader_pkg.sv - shared types and helpers for the quadtree loader
// Provides the node record payload type, the loader FSM state encoding and
// the per-stage address width function used by the loader and its users.
package qtree_loader_pkg;

  localparam int D_WIDTH_DEF = 16;

  // Node thresholds as stored in each qstage RAM word.
  typedef struct packed {
    logic [D_WIDTH_DEF-1:0] l;
    logic [D_WIDTH_DEF-1:0] m;
    logic [D_WIDTH_DEF-1:0] r;
  } ram_data_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } ld_state_t;

  // Stage s holds 4**s nodes, so it needs 2*s address bits (at least one).
  function automatic int stage_aw(input int s);
    return (2 * s > 1) ? 2 * s : 1;
  endfunction

endpackage

// File: rtl/qtree_loader_fifo.sv
// rtl/qtree_loader_fifo.sv - synchronous record buffer for the quadtree loader
// Ports: push_i/data_i write side, pop_i/data_o read side (data_o shows the
// head entry while not empty), full_o/empty_o/count_o status. A push when full
// or a pop when empty is ignored.
module qtree_loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/qtree_loader.sv
// rtl/qtree_loader.sv - batch write controller for the quadtree lookup pipeline
// Ports: in_* record stream from the host (valid/ready, stage/addr/data/last),
// lookup_hold_o stalls upstream lookups, stage_wr_* drives the qstage write
// ports, busy_o/err_o/err_clr_i/wr_cnt_o give status.
module qtree_loader
  import qtree_loader_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DRAIN_CYC  = 2 * STAGES
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] in_stage_i,
  input  logic [2*(STAGES-1)-1:0]                      in_addr_i,
  input  logic [3*D_WIDTH-1:0]                         in_data_i,
  input  logic                                         in_last_i,
  output logic                                         lookup_hold_o,
  output logic [STAGES-1:0]                            stage_wr_en_o,
  output logic [2*(STAGES-1)-1:0]                      stage_wr_addr_o,
  output logic [3*D_WIDTH-1:0]                         stage_wr_data_o,
  output logic                                         busy_o,
  output logic                                         err_o,
  input  logic                                         err_clr_i,
  output logic [15:0]                                  wr_cnt_o
);

  localparam int MAX_AW = 2 * (STAGES - 1);
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int DW     = 3 * D_WIDTH;
  localparam int RW     = SW + MAX_AW + DW + 1;
  localparam int CNTW   = $clog2(DRAIN_CYC + 1);

  ld_state_t               state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic                    hold_q, hold_d;
  logic [STAGES-1:0]       wr_en_q, wr_en_d;
  logic [MAX_AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DW-1:0]           wr_data_q, wr_data_d;
  logic                    err_q, err_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic                    rdy_en_q;

  logic [RW-1:0]           fifo_din, fifo_dout;
  logic                    fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic [SW-1:0]           rec_stage;
  logic [MAX_AW-1:0]       rec_addr;
  logic [DW-1:0]           rec_data;
  logic                    rec_last;
  logic                    rec_ok;

  // rdy_en_q keeps ready low while reset is applied and for no longer.
  assign in_ready_o = rdy_en_q & ~fifo_full;
  assign fifo_push  = in_valid_i & in_ready_o;
  assign fifo_din   = {in_stage_i, in_addr_i, in_data_i, in_last_i};

  qtree_loader_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rec_stage = fifo_dout[RW-1 -: SW];
  assign rec_addr  = fifo_dout[RW-SW-1 -: MAX_AW];
  assign rec_data  = fifo_dout[DW:1];
  assign rec_last  = fifo_dout[0];

  // A record is writable only if its stage exists and its address fits
  // inside that stage's narrower address space.
  always_comb begin
    rec_ok = 1'b0;
    if (int'(rec_stage) < STAGES) begin
      rec_ok = ((32'(rec_addr) >> stage_aw(int'(rec_stage))) == 32'd0);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    wr_cnt_d  = wr_cnt_q;
    fifo_pop  = 1'b0;

    // A drop later in this block overrides the clear.
    if (err_clr_i) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          state_d = ST_DRAIN;
          hold_d  = 1'b1;
          cnt_d   = CNTW'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_WRITE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WRITE: begin
        // An empty FIFO before the closing record just waits with hold kept.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (rec_ok) begin
            wr_en_d   = STAGES'(1) << rec_stage;
            wr_addr_d = rec_addr;
            wr_data_d = rec_data;
            wr_cnt_d  = wr_cnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
          if (rec_last) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      wr_cnt_q  <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      wr_cnt_q  <= wr_cnt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign lookup_hold_o   = hold_q;
  assign stage_wr_en_o   = wr_en_q;
  assign stage_wr_addr_o = wr_addr_q;
  assign stage_wr_data_o = wr_data_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign err_o           = err_q;
  assign wr_cnt_o        = wr_cnt_q;

endmodule

// File: tb/tb_qtree_loader.sv
// tb/tb_qtree_loader.sv - directed self-checking bench for qtree_loader
module tb_qtree_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [1:0]  in_stage_i = '0;
  logic [5:0]  in_addr_i = '0;
  logic [47:0] in_data_i = '0;
  logic        in_last_i = 1'b0;
  logic        lookup_hold_o;
  logic [3:0]  stage_wr_en_o;
  logic [5:0]  stage_wr_addr_o;
  logic [47:0] stage_wr_data_o;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i = 1'b0;
  logic [15:0] wr_cnt_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qtree_loader dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_stage_i      (in_stage_i),
    .in_addr_i       (in_addr_i),
    .in_data_i       (in_data_i),
    .in_last_i       (in_last_i),
    .lookup_hold_o   (lookup_hold_o),
    .stage_wr_en_o   (stage_wr_en_o),
    .stage_wr_addr_o (stage_wr_addr_o),
    .stage_wr_data_o (stage_wr_data_o),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i),
    .wr_cnt_o        (wr_cnt_o)
  );

  typedef struct {
    logic [3:0]  en;
    logic [5:0]  addr;
    logic [47:0] data;
    int          t;
    logic        hold;
  } wr_t;

  wr_t  wlog[$];
  int   hold_rises = 0;
  int   hold_rise_cyc = 0;
  logic hold_prev = 1'b0;

  always @(negedge clk) begin
    if (stage_wr_en_o != 4'b0000)
      wlog.push_back('{stage_wr_en_o, stage_wr_addr_o, stage_wr_data_o, cyc, lookup_hold_o});
    if (lookup_hold_o && !hold_prev) begin
      hold_rises++;
      hold_rise_cyc = cyc;
    end
    hold_prev = lookup_hold_o;
  end

  function automatic logic [47:0] mkd(input int i);
    logic [15:0] a, b, c;
    a = 16'(i * 3 + 1);
    b = 16'(i * 3 + 2);
    c = 16'(i * 3 + 3);
    return {a, b, c};
  endfunction

  task automatic push(input logic [1:0] st, input logic [5:0] a, input logic [47:0] d,
                      input logic last, output int acc_cyc);
    logic rdy;
    int   n = 0;
    in_valid_i = 1'b1;
    in_stage_i = st;
    in_addr_i  = a;
    in_data_i  = d;
    in_last_i  = last;
    forever begin
      rdy = in_ready_o;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 300) begin
        chk_cnt++;
        $display("FAIL push_timeout: ready never seen, waited %0d cycles, limit 300", n);
        break;
      end
    end
    acc_cyc = cyc;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_done(input int nwr, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk);
      #1;
      if (wlog.size() >= nwr && !busy_o && !lookup_hold_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++; if (in_ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", in_ready_o); else pass_cnt++;
    chk_cnt++; if (lookup_hold_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL reset_status: got hold=%b busy=%b err=%b expected 0/0/0", lookup_hold_o, busy_o, err_o); else pass_cnt++;
    chk_cnt++; if (stage_wr_en_o !== 4'b0 || wr_cnt_o !== 16'd0)
      $display("FAIL reset_wr: got en=%b cnt=%0d expected 0/0", stage_wr_en_o, wr_cnt_o); else pass_cnt++;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    chk_cnt++; if (in_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", in_ready_o); else pass_cnt++;
  endtask

  task automatic test_single();
    int acc, r0;
    bit ok;
    wlog.delete();
    r0 = hold_rises;
    push(2'd2, 6'd5, mkd(0), 1'b1, acc);
    wait_done(1, ok);
    chk_cnt++; if (!ok) $display("FAIL single_done: got timeout expected completion"); else pass_cnt++;
    chk_cnt++; if (hold_rises - r0 !== 1 || hold_rise_cyc !== acc + 1)
      $display("FAIL single_hold_rise: got rises=%0d at %0d expected 1 at %0d", hold_rises - r0, hold_rise_cyc, acc + 1); else pass_cnt++;
    chk_cnt++; if (wlog.size() !== 1) $display("FAIL single_count: got %0d writes expected 1", wlog.size()); else pass_cnt++;
    if (wlog.size() >= 1) begin
      chk_cnt++; if (wlog[0].en !== 4'b0100 || wlog[0].addr !== 6'd5 || wlog[0].data !== mkd(0))
        $display("FAIL single_write: got en=%b addr=%0d data=%h expected 0100/5/%h", wlog[0].en, wlog[0].addr, wlog[0].data, mkd(0)); else pass_cnt++;
      chk_cnt++; if (wlog[0].t !== hold_rise_cyc + 9)
        $display("FAIL single_latency: got write at %0d expected %0d", wlog[0].t, hold_rise_cyc + 9); else pass_cnt++;
    end
    chk_cnt++; if (wr_cnt_o !== 16'd1 || lookup_hold_o !== 1'b0)
      $display("FAIL single_after: got cnt=%0d hold=%b expected 1/0", wr_cnt_o, lookup_hold_o); else pass_cnt++;
  endtask

  task automatic test_batch();
    int acc, r0;
    bit ok;
    wlog.delete();
    r0 = hold_rises;
    push(2'd0, 6'd1,  mkd(1), 1'b0, acc);
    push(2'd1, 6'd3,  mkd(2), 1'b0, acc);
    push(2'd3, 6'd63, mkd(3), 1'b1, acc);
    wait_done(3, ok);
    chk_cnt++; if (!ok || wlog.size() !== 3)
      $display("FAIL batch_count: got ok=%0d writes=%0d expected 1/3", ok, wlog.size()); else pass_cnt++;
    if (wlog.size() == 3) begin
      chk_cnt++; if (wlog[0].en !== 4'b0001 || wlog[1].en !== 4'b0010 || wlog[2].en !== 4'b1000)
        $display("FAIL batch_order: got %b %b %b expected 0001 0010 1000", wlog[0].en, wlog[1].en, wlog[2].en); else pass_cnt++;
      chk_cnt++; if (wlog[0].addr !== 6'd1 || wlog[1].addr !== 6'd3 || wlog[2].addr !== 6'd63 || wlog[2].data !== mkd(3))
        $display("FAIL batch_addr: got %0d %0d %0d expected 1 3 63", wlog[0].addr, wlog[1].addr, wlog[2].addr); else pass_cnt++;
      chk_cnt++; if (wlog[1].t !== wlog[0].t + 1 || wlog[2].t !== wlog[0].t + 2)
        $display("FAIL batch_consecutive: got t=%0d %0d %0d expected consecutive", wlog[0].t, wlog[1].t, wlog[2].t); else pass_cnt++;
    end
    chk_cnt++; if (hold_rises - r0 !== 1 || wr_cnt_o !== 16'd4)
      $display("FAIL batch_window: got rises=%0d cnt=%0d expected 1/4", hold_rises - r0, wr_cnt_o); else pass_cnt++;
  endtask

  task automatic test_full();
    int acc, r0, nbad;
    bit ok;
    wlog.delete();
    r0 = hold_rises;
    for (int i = 0; i < 8; i++) push(2'(i % 4), 6'(i % 2), mkd(10 + i), (i == 7), acc);
    chk_cnt++; if (in_ready_o !== 1'b0) $display("FAIL full_ready: got %b expected 0 after 8 records", in_ready_o); else pass_cnt++;
    in_valid_i = 1'b1;
    in_stage_i = 2'd0;
    in_addr_i  = 6'd0;
    in_data_i  = mkd(18);
    idle_cycles(1);
    chk_cnt++; if (in_ready_o !== 1'b0 || wlog.size() !== 0)
      $display("FAIL full_stall: got ready=%b writes=%0d expected 0/0", in_ready_o, wlog.size()); else pass_cnt++;
    push(2'd0, 6'd0, mkd(18), 1'b0, acc);
    push(2'd1, 6'd1, mkd(19), 1'b1, acc);
    wait_done(10, ok);
    chk_cnt++; if (!ok || wlog.size() !== 10)
      $display("FAIL full_count: got ok=%0d writes=%0d expected 1/10", ok, wlog.size()); else pass_cnt++;
    nbad = 0;
    for (int i = 0; i < wlog.size() && i < 10; i++)
      if (wlog[i].en !== 4'(1 << (i % 4)) || wlog[i].addr !== 6'(i % 2) || wlog[i].data !== mkd(10 + i)) nbad++;
    chk_cnt++; if (nbad !== 0) $display("FAIL full_order: got %0d wrong records expected 0", nbad); else pass_cnt++;
    chk_cnt++; if (hold_rises - r0 !== 2 || wr_cnt_o !== 16'd14)
      $display("FAIL full_windows: got rises=%0d cnt=%0d expected 2/14", hold_rises - r0, wr_cnt_o); else pass_cnt++;
  endtask

  task automatic test_err();
    int acc;
    bit ok;
    wlog.delete();
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL err_initial: got %b expected 0", err_o); else pass_cnt++;
    push(2'd0, 6'd1, mkd(30), 1'b0, acc);
    push(2'd1, 6'd4, mkd(31), 1'b0, acc);
    push(2'd2, 6'd7, mkd(32), 1'b1, acc);
    wait_done(2, ok);
    idle_cycles(2);
    chk_cnt++; if (!ok || err_o !== 1'b1)
      $display("FAIL err_set: got ok=%0d err=%b expected 1/1", ok, err_o); else pass_cnt++;
    chk_cnt++; if (wlog.size() !== 2 || wr_cnt_o !== 16'd16)
      $display("FAIL err_writes: got writes=%0d cnt=%0d expected 2/16", wlog.size(), wr_cnt_o); else pass_cnt++;
    if (wlog.size() == 2) begin
      chk_cnt++; if (wlog[0].en !== 4'b0001 || wlog[1].en !== 4'b0100 || wlog[1].addr !== 6'd7)
        $display("FAIL err_skip: got %b %b addr=%0d expected 0001 0100 7", wlog[0].en, wlog[1].en, wlog[1].addr); else pass_cnt++;
    end
    err_clr_i = 1'b1;
    idle_cycles(1);
    err_clr_i = 1'b0;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL err_clear: got %b expected 0", err_o); else pass_cnt++;
  endtask

  task automatic test_gap();
    int acc, r0, nbad;
    bit ok;
    wlog.delete();
    r0 = hold_rises;
    push(2'd3, 6'd40, mkd(40), 1'b0, acc);
    push(2'd2, 6'd9,  mkd(41), 1'b0, acc);
    idle_cycles(14);
    chk_cnt++; if (lookup_hold_o !== 1'b1 || busy_o !== 1'b1 || wlog.size() !== 2)
      $display("FAIL gap_hold: got hold=%b busy=%b writes=%0d expected 1/1/2", lookup_hold_o, busy_o, wlog.size()); else pass_cnt++;
    push(2'd1, 6'd2, mkd(42), 1'b1, acc);
    wait_done(3, ok);
    chk_cnt++; if (!ok || wlog.size() !== 3 || hold_rises - r0 !== 1)
      $display("FAIL gap_window: got ok=%0d writes=%0d rises=%0d expected 1/3/1", ok, wlog.size(), hold_rises - r0); else pass_cnt++;
    nbad = 0;
    foreach (wlog[i]) if (wlog[i].hold !== 1'b1) nbad++;
    if (wlog.size() == 3) begin
      if (wlog[0].en !== 4'b1000 || wlog[1].en !== 4'b0100 || wlog[2].en !== 4'b0010 || wlog[2].data !== mkd(42)) nbad++;
      if (wlog[2].t <= wlog[1].t + 1) nbad++;
    end
    chk_cnt++; if (nbad !== 0) $display("FAIL gap_writes: got %0d bad writes expected 0", nbad); else pass_cnt++;
    chk_cnt++; if (wr_cnt_o !== 16'd19) $display("FAIL gap_cnt: got %0d expected 19", wr_cnt_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acc, r0;
    wlog.delete();
    push(2'd2, 6'd5, mkd(50), 1'b1, acc);
    idle_cycles(3);
    chk_cnt++; if (lookup_hold_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL rstmid_drain: got hold=%b busy=%b expected 1/1", lookup_hold_o, busy_o); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (lookup_hold_o !== 1'b0 || busy_o !== 1'b0 || stage_wr_en_o !== 4'b0 || in_ready_o !== 1'b0)
      $display("FAIL rstmid_async: got hold=%b busy=%b en=%b ready=%b expected 0/0/0000/0", lookup_hold_o, busy_o, stage_wr_en_o, in_ready_o); else pass_cnt++;
    idle_cycles(1);
    rst = 1'b0;
    r0 = hold_rises;
    idle_cycles(20);
    chk_cnt++; if (wr_cnt_o !== 16'd0 || wlog.size() !== 0 || hold_rises !== r0)
      $display("FAIL rstmid_empty: got cnt=%0d writes=%0d rises=%0d expected 0/0/0", wr_cnt_o, wlog.size(), hold_rises - r0); else pass_cnt++;
    chk_cnt++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL rstmid_ready: got ready=%b busy=%b expected 1/0", in_ready_o, busy_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_batch();
    test_full();
    test_err();
    test_gap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
